// File: rtl/aes_inv_key_sched.sv
// AES-128 key expansion into an 11-entry round-key store, streamed out 10..0 over valid/ready.
// Optional macro AES_KS_FWD_ORDER_EN adds rk_dir to select a forward 0..10 stream.
module aes_inv_key_sched #(
    parameter int NR    = 10,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [127:0]     key_in,
    input  logic             key_load,
    input  logic             rk_start,
    input  logic             rk_ready,
`ifdef AES_KS_FWD_ORDER_EN
    input  logic             rk_dir,
`endif
    output logic             rk_valid,
    output logic [127:0]     rk_out,
    output logic [IDX_W-1:0] rk_idx,
    output logic             rk_last,
    output logic             keys_ready,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXPAND = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;
    localparam logic [1:0] S_SERVE  = 2'd3;

    localparam int               CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_NR = CNT_W'(NR);
    localparam logic [IDX_W-1:0] IDX_NR = IDX_W'(NR);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[(255 - int'(b)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [CNT_W-1:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [127:0]     store [0:NR];
    logic [127:0]     work_key;
    logic             dir_q;
    logic             start_fwd;

`ifdef AES_KS_FWD_ORDER_EN
    assign start_fwd = rk_dir;
`else
    assign start_fwd = 1'b0;
`endif

    // One FIPS-197 expansion step on the most recently produced round key.
    logic [31:0]  w3_rot, w3_sub, nw0, nw1, nw2, nw3;
    logic [127:0] next_key;

    assign w3_rot   = {work_key[23:0], work_key[31:24]};
    assign w3_sub   = {sbox(w3_rot[31:24]), sbox(w3_rot[23:16]),
                       sbox(w3_rot[15:8]),  sbox(w3_rot[7:0])};
    assign nw0      = work_key[127:96] ^ w3_sub ^ {rcon(cnt), 24'h0};
    assign nw1      = work_key[95:64] ^ nw0;
    assign nw2      = work_key[63:32] ^ nw1;
    assign nw3      = work_key[31:0]  ^ nw2;
    assign next_key = {nw0, nw1, nw2, nw3};

    logic [IDX_W-1:0] start_idx, start_stop, stop_idx, step_idx;

    assign start_idx  = start_fwd ? '0 : IDX_NR;
    assign start_stop = start_fwd ? IDX_NR : '0;
    assign stop_idx   = dir_q ? IDX_NR : '0;
    assign step_idx   = dir_q ? rk_idx + 1'b1 : rk_idx - 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (key_load) begin
                store[0] <= key_in;
                work_key <= key_in;
            end else if (state == S_EXPAND) begin
                store[cnt] <= next_key;
                work_key   <= next_key;
            end
        end
    end

    // Handshake: a beat transfers on any edge where rk_valid && rk_ready; while rk_valid is
    // high and rk_ready low, rk_out/rk_idx/rk_last hold; rk_valid never drops without a
    // transfer except on key_load or rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            dir_q      <= 1'b0;
            rk_valid   <= 1'b0;
            rk_out     <= '0;
            rk_idx     <= '0;
            rk_last    <= 1'b0;
            keys_ready <= 1'b0;
            busy       <= 1'b0;
        end else if (key_load) begin
            state      <= S_EXPAND;
            cnt        <= CNT_W'(1);
            rk_valid   <= 1'b0;
            rk_out     <= '0;
            rk_idx     <= '0;
            rk_last    <= 1'b0;
            keys_ready <= 1'b0;
            busy       <= 1'b1;
        end else begin
            case (state)
                S_EXPAND: begin
                    if (cnt == CNT_NR) begin
                        state      <= S_HOLD;
                        busy       <= 1'b0;
                        keys_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (rk_start) begin
                        state    <= S_SERVE;
                        dir_q    <= start_fwd;
                        rk_valid <= 1'b1;
                        rk_idx   <= start_idx;
                        rk_out   <= store[start_idx];
                        rk_last  <= (start_idx == start_stop);
                    end
                end
                S_SERVE: begin
                    if (rk_valid && rk_ready) begin
                        if (rk_idx == stop_idx) begin
                            state    <= S_HOLD;
                            rk_valid <= 1'b0;
                            rk_out   <= '0;
                            rk_idx   <= '0;
                            rk_last  <= 1'b0;
                        end else begin
                            rk_idx  <= step_idx;
                            rk_out  <= store[step_idx];
                            rk_last <= (step_idx == stop_idx);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign dbg_state = state;

endmodule
